fifo_rd_packer: RTL

- Sits directly downstream of the standard (non-FWFT) dual-clock FIFO, in its read clock domain.
- Pulls IN_WIDTH beats from the FIFO read port (rd_en / dout / empty, one-cycle read latency) and packs RATIO consecutive beats into one OUT_WIDTH word.
- Presents the packed word on a registered valid/ready stream for the wide logic-side consumer.
- A flush request emits a partially filled word so that trailing bytes are not stranded.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_rd_packer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the FIFO read-side packer
//
// Purpose: flush state machine encoding and the beat-count width helper.
package fifo_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH_WAIT = 2'd1,
    FLUSH_EMIT = 2'd2
  } pack_state_t;

  // Width needed to hold a beat count in the range 0..ratio.
  function automatic int count_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - packs RATIO narrow FIFO beats into one wide stream word
//
// Purpose: drains a standard (non-FWFT) FIFO read port with one-cycle read
// latency, assembles RATIO beats LSB-first and presents them on a registered
// valid/ready stream. A flush pulse emits a partially filled word.
//
// Ports:
//   clk, rst_n        read-domain clock, asynchronous active-low reset
//   fifo_rd_en        read strobe to the FIFO
//   fifo_dout         FIFO data, valid the cycle after fifo_rd_en
//   fifo_empty        FIFO empty flag
//   flush             single-cycle request to emit the partial word
//   out_data          packed word, beat 0 in the least significant slot
//   out_count         number of valid beats in out_data
//   out_valid         out_data/out_count valid
//   out_ready         consumer accepts on out_valid && out_ready
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int RATIO     = 4,
  parameter int OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          fifo_rd_en,
  input  logic [IN_WIDTH-1:0]           fifo_dout,
  input  logic                          fifo_empty,
  input  logic                          flush,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic [count_width(RATIO)-1:0] out_count,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int CNT_W  = count_width(RATIO);
  localparam int SLOT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RATIO);

  pack_state_t          state_q, state_d;
  logic                 flush_req_q, flush_req_d;
  logic                 rd_pending_q;
  logic [CNT_W-1:0]     fill_q, fill_d;
  logic [IN_WIDTH-1:0]  asm_q [RATIO];
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]     out_count_q, out_count_d;
  logic                 out_valid_q, out_valid_d;

  logic                 move;
  logic [CNT_W-1:0]     base_fill;
  logic [CNT_W:0]       reserved;
  logic                 asm_we;
  logic [SLOT_W-1:0]    asm_idx;
  logic [OUT_WIDTH-1:0] packed_word;

  // Read issue: count slots already owned (held beats plus the one in flight)
  // so the assembly register can never overflow and no beat is dropped.
  always_comb begin
    move       = ((fill_q == FULL) || (state_q == FLUSH_EMIT)) &&
                 (!out_valid_q || out_ready);
    base_fill  = move ? '0 : fill_q;
    reserved   = {1'b0, base_fill} + (CNT_W+1)'(rd_pending_q);
    fifo_rd_en = !fifo_empty && (state_q == RUN) && !flush_req_q &&
                 (reserved < (CNT_W+1)'(RATIO));
  end

  // Unused upper slots of a partial word are forced to zero.
  always_comb begin
    packed_word = '0;
    for (int i = 0; i < RATIO; i++) begin
      packed_word[i*IN_WIDTH +: IN_WIDTH] = (i < int'(fill_q)) ? asm_q[i] : '0;
    end
  end

  // Assembly and output register next state. A beat arriving in the same
  // cycle as a move starts the next word in slot 0.
  always_comb begin
    fill_d      = fill_q;
    asm_we      = 1'b0;
    asm_idx     = fill_q[SLOT_W-1:0];
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    if (move) begin
      fill_d      = rd_pending_q ? CNT_W'(1) : '0;
      asm_we      = rd_pending_q;
      asm_idx     = '0;
      out_data_d  = packed_word;
      out_count_d = fill_q;
      out_valid_d = 1'b1;
    end else begin
      if (rd_pending_q) begin
        fill_d = fill_q + CNT_W'(1);
        asm_we = 1'b1;
      end
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Flush sequencing: let the in-flight beat land and any full word leave
  // before deciding whether there is a partial word to emit.
  always_comb begin
    state_d     = state_q;
    flush_req_d = flush_req_q;
    unique case (state_q)
      RUN: begin
        if (flush) begin
          flush_req_d = 1'b1;
          state_d     = FLUSH_WAIT;
        end
      end
      FLUSH_WAIT: begin
        if (!rd_pending_q && (fill_q != FULL)) begin
          if (fill_q != '0) begin
            state_d = FLUSH_EMIT;
          end else begin
            state_d     = RUN;
            flush_req_d = 1'b0;
          end
        end
      end
      FLUSH_EMIT: begin
        if (move) begin
          state_d     = RUN;
          flush_req_d = 1'b0;
        end
      end
      default: begin
        state_d     = RUN;
        flush_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      flush_req_q  <= 1'b0;
      rd_pending_q <= 1'b0;
      fill_q       <= '0;
      out_data_q   <= '0;
      out_count_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_req_q  <= flush_req_d;
      rd_pending_q <= fifo_rd_en;
      fill_q       <= fill_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      out_valid_q  <= out_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RATIO; i++) begin
        asm_q[i] <= '0;
      end
    end else if (asm_we) begin
      asm_q[asm_idx] <= fifo_dout;
    end
  end

  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_valid = out_valid_q;

endmodule
